// File: rtl/atm_pkg.sv
// Shared types, encodings and power-on tables for the ATM session controller.
// Imported by the interface, the account bank and the controller.
package atm_pkg;

  localparam int NUM_ACCT    = 16;
  localparam int ACCT_W      = 4;
  localparam int BAL_W       = 10;
  localparam int PIN_W       = 4;
  localparam int MAX_TRIES   = 3;
  localparam int TIMEOUT_CYC = 255;
  localparam int TMO_W       = 8;
  localparam int TRY_W       = 2;

  typedef logic [BAL_W-1:0]  bal_t;
  typedef logic [ACCT_W-1:0] acct_t;
  typedef logic [PIN_W-1:0]  pin_t;

  typedef enum logic [1:0] {
    SEL_DISP  = 2'b00,
    SEL_WDRAW = 2'b01,
    SEL_XFER  = 2'b10,
    SEL_EXIT  = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    RES_REJ  = 2'b00,
    RES_OK   = 2'b01,
    RES_LOCK = 2'b10,
    RES_TMO  = 2'b11
  } res_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PIN_WAIT,
    S_MENU,
    S_EXEC,
    S_CREDIT,
    S_REPORT
  } state_e;

  localparam bal_t INIT_BAL [NUM_ACCT] = '{
    10'd214, 10'd502, 10'd237, 10'd109,
    10'd1000, 10'd15, 10'd600, 10'd42,
    10'd777, 10'd1, 10'd333, 10'd256,
    10'd90, 10'd1023, 10'd512, 10'd64
  };

  function automatic pin_t init_pin(input acct_t a);
    return a ^ 4'hA;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Terminal-side request/response bundle of the ATM session controller.
// master = terminal front end, slave = controller.
interface atm_session_ctrl_if;
  import atm_pkg::*;

  logic       start;
  acct_t      acct_in;
  logic       pin_valid;
  pin_t       pin_in;
  logic       op_valid;
  logic [1:0] select;
  acct_t      dest_acct;
  bal_t       amount;
  logic       busy;
  logic       done;
  logic [1:0] result;
  bal_t       balance_out;

  modport master (
    output start, acct_in, pin_valid, pin_in,
    output op_valid, select, dest_acct, amount,
    input  busy, done, result, balance_out
  );

  modport slave (
    input  start, acct_in, pin_valid, pin_in,
    input  op_valid, select, dest_acct, amount,
    output busy, done, result, balance_out
  );

endinterface

// File: rtl/atm_account_bank.sv
// Balance store: one combinational read port, one synchronous write port,
// reloaded from INIT_BAL on reset.
module atm_account_bank
  import atm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  acct_t raddr_i,
  output bal_t  rdata_o,
  input  logic  we_i,
  input  acct_t waddr_i,
  input  bal_t  wdata_i
);

  bal_t mem_q [NUM_ACCT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCT; i++)
        mem_q[i] <= INIT_BAL[i];
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/atm_session_ctrl.sv
// One-session-at-a-time ATM controller: PIN check with lockout, menu loop,
// and serialized debit/credit against the account bank.
module atm_session_ctrl
  import atm_pkg::*;
(
  input logic clk,
  input logic rst,
  atm_session_ctrl_if.slave bus
);

  state_e               state_q, state_d;
  acct_t                acct_q, acct_d;
  acct_t                dest_q, dest_d;
  bal_t                 amt_q, amt_d;
  bal_t                 obal_q, obal_d;
  sel_e                 sel_q, sel_d;
  res_e                 pend_q, pend_d;
  res_e                 res_q, res_d;
  bal_t                 bout_q, bout_d;
  logic                 done_q, done_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [NUM_ACCT-1:0]  lock_q, lock_d;

  acct_t            raddr;
  bal_t             rdata;
  logic             we;
  acct_t            waddr;
  bal_t             wdata;
  logic [BAL_W:0]   sum;
  logic             tmo_hit;

  atm_account_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .raddr_i (raddr),
    .rdata_o (rdata),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acct_q  <= '0;
      dest_q  <= '0;
      amt_q   <= '0;
      obal_q  <= '0;
      sel_q   <= SEL_DISP;
      pend_q  <= RES_REJ;
      res_q   <= RES_REJ;
      bout_q  <= '0;
      done_q  <= 1'b0;
      tries_q <= '0;
      tmo_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      acct_q  <= acct_d;
      dest_q  <= dest_d;
      amt_q   <= amt_d;
      obal_q  <= obal_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      tries_q <= tries_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
    end
  end

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC));
  // rdata is the destination balance whenever raddr points at dest_q
  assign sum = {1'b0, rdata} + {1'b0, amt_q};

  always_comb begin
    state_d = state_q;
    acct_d  = acct_q;
    dest_d  = dest_q;
    amt_d   = amt_q;
    obal_d  = obal_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    res_d   = res_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    tries_d = tries_q;
    tmo_d   = '0;
    lock_d  = lock_q;
    raddr   = acct_q;
    we      = 1'b0;
    waddr   = acct_q;
    wdata   = rdata;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acct_d = bus.acct_in;
          if (lock_q[bus.acct_in]) begin
            done_d = 1'b1;
            res_d  = RES_LOCK;
          end else begin
            tries_d = '0;
            state_d = S_PIN_WAIT;
          end
        end
      end

      S_PIN_WAIT: begin
        if (bus.pin_valid) begin
          if (bus.pin_in == init_pin(acct_q)) begin
            state_d = S_MENU;
          end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            lock_d[acct_q] = 1'b1;
            done_d  = 1'b1;
            res_d   = RES_LOCK;
            state_d = S_IDLE;
          end else begin
            tries_d = tries_q + 1'b1;
            done_d  = 1'b1;
            res_d   = RES_REJ;
          end
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          res_d   = RES_TMO;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_MENU: begin
        if (bus.op_valid) begin
          if (sel_e'(bus.select) == SEL_EXIT) begin
            done_d  = 1'b1;
            res_d   = RES_OK;
            bout_d  = rdata;
            state_d = S_IDLE;
          end else begin
            sel_d   = sel_e'(bus.select);
            dest_d  = bus.dest_acct;
            amt_d   = bus.amount;
            obal_d  = rdata;
            state_d = S_EXEC;
          end
        end else if (tmo_hit) begin
          done_d  = 1'b1;
          res_d   = RES_TMO;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_EXEC: begin
        state_d = S_REPORT;
        pend_d  = RES_REJ;
        case (sel_q)
          SEL_DISP: pend_d = RES_OK;
          SEL_WDRAW: begin
            if (amt_q <= obal_q) begin
              we     = 1'b1;
              wdata  = obal_q - amt_q;
              pend_d = RES_OK;
            end
          end
          SEL_XFER: begin
            raddr = dest_q;
            if ((dest_q != acct_q) && (amt_q <= obal_q)
                && !sum[BAL_W]) begin
              we      = 1'b1;
              wdata   = obal_q - amt_q;
              pend_d  = RES_OK;
              state_d = S_CREDIT;
            end
          end
          default: pend_d = RES_REJ;
        endcase
      end

      S_CREDIT: begin
        raddr   = dest_q;
        we      = 1'b1;
        waddr   = dest_q;
        wdata   = sum[BAL_W-1:0];
        state_d = S_REPORT;
      end

      S_REPORT: begin
        done_d  = 1'b1;
        res_d   = pend_q;
        bout_d  = rdata;
        state_d = S_MENU;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.result      = res_q;
  assign bus.balance_out = bout_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: stimulus pushes expected done
// events, a negedge monitor pops and compares result/balance/cycle.
module tb_atm_session_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  atm_session_ctrl_if bus();

  atm_session_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] res;
    logic [9:0] bal;
    bit         cb;
    int         cyc;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t me;

  always @(negedge clk) begin
    if (bus.done) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done res=%0b bal=%0d cyc=%0d",
                 bus.result, bus.balance_out, cyc);
      end else begin
        me = q.pop_front();
        if (bus.result !== me.res || cyc != me.cyc ||
            (me.cb && bus.balance_out !== me.bal)) begin
          errors++;
          $display("FAIL %s got res=%0b bal=%0d cyc=%0d want res=%0b bal=%0d cyc=%0d",
                   me.nm, bus.result, bus.balance_out, cyc,
                   me.res, me.bal, me.cyc);
        end
      end
    end
  end

  task automatic expect_done(input logic [1:0] r, input logic [9:0] b,
                             input bit cb, input int lat,
                             input string nm);
    exp_t e;
    e.res = r; e.bal = b; e.cb = cb;
    e.cyc = cyc + 1 + lat; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic rel(input int n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.pin_valid = 1'b0;
    bus.op_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drv_start(input logic [3:0] a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.acct_in = a;
  endtask

  task automatic drv_pin(input logic [3:0] p);
    @(negedge clk);
    bus.pin_valid = 1'b1;
    bus.pin_in = p;
  endtask

  task automatic drv_op(input logic [1:0] s, input logic [3:0] d,
                        input logic [9:0] a);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.select = s;
    bus.dest_acct = d;
    bus.amount = a;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_result"}, int'(bus.result), 0);
    chk({tag, "_bal"}, int'(bus.balance_out), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pin_valid = 1'b0;
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset(tag);
  endtask

  task automatic login(input logic [3:0] a);
    drv_start(a); rel(1);
    drv_pin(a ^ 4'hA); rel(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.acct_in = '0;
    bus.pin_valid = 1'b0; bus.pin_in = '0;
    bus.op_valid = 1'b0; bus.select = '0;
    bus.dest_acct = '0; bus.amount = '0;
    do_reset("rst0");

    // acct 0 display and exit
    drv_start(4'd0); rel(1);
    chk("busy_pin_wait", int'(bus.busy), 1);
    drv_pin(4'hA); rel(1);
    drv_op(2'b00, 4'd0, 10'd0);
    expect_done(2'b01, 10'd214, 1, 2, "disp0"); rel(3);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd214, 1, 0, "exit0"); rel(2);
    chk("busy_after_exit", int'(bus.busy), 0);

    // acct 1 withdraws
    login(4'd1);
    drv_op(2'b01, 4'd0, 10'd600);
    expect_done(2'b00, 10'd502, 1, 2, "wd600"); rel(3);
    drv_op(2'b01, 4'd0, 10'd502);
    expect_done(2'b01, 10'd0, 1, 2, "wd502"); rel(3);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd0, 1, 0, "exit1"); rel(2);

    // acct 3 -> acct 2 transfer
    login(4'd3);
    drv_op(2'b10, 4'd2, 10'd100);
    expect_done(2'b01, 10'd9, 1, 3, "xfer3to2"); rel(4);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd9, 1, 0, "exit3"); rel(2);

    login(4'd2);
    drv_op(2'b00, 4'd0, 10'd0);
    expect_done(2'b01, 10'd337, 1, 2, "disp2"); rel(3);
    drv_op(2'b10, 4'd2, 10'd1);
    expect_done(2'b00, 10'd337, 1, 2, "xfer_self"); rel(3);
    drv_op(2'b10, 4'd4, 10'd30);
    expect_done(2'b00, 10'd337, 1, 2, "xfer_ovf"); rel(3);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd337, 1, 0, "exit2"); rel(2);

    // PIN lockout on acct 0
    drv_start(4'd0); rel(1);
    drv_pin(4'd1);
    expect_done(2'b00, 10'd0, 0, 0, "pin1"); rel(1);
    drv_pin(4'd2);
    expect_done(2'b00, 10'd0, 0, 0, "pin2"); rel(1);
    drv_pin(4'd3);
    expect_done(2'b10, 10'd0, 0, 0, "pin3_lock"); rel(1);
    chk("busy_after_lock", int'(bus.busy), 0);
    drv_start(4'd0);
    expect_done(2'b10, 10'd0, 0, 0, "start_locked"); rel(1);
    chk("busy_locked_start", int'(bus.busy), 0);

    do_reset("rst1");
    login(4'd0);
    chk("busy_unlock", int'(bus.busy), 1);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd214, 1, 0, "exit_unlock"); rel(2);

    // MENU timeout
    drv_start(4'd0); rel(1);
    drv_pin(4'hA);
    expect_done(2'b11, 10'd0, 0, 256, "timeout"); rel(257);
    chk("busy_timeout", int'(bus.busy), 0);

    // op on the expiry cycle wins
    drv_start(4'd0); rel(1);
    drv_pin(4'hA); rel(1);
    repeat (254) @(negedge clk);
    drv_op(2'b00, 4'd0, 10'd0);
    expect_done(2'b01, 10'd214, 1, 2, "op_at_expiry"); rel(3);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd214, 1, 0, "exit_expiry"); rel(2);

    // reset during CREDIT
    login(4'd3);
    drv_op(2'b10, 4'd2, 10'd50); rel(1);
    do_reset("rst_credit");
    login(4'd3);
    drv_op(2'b00, 4'd0, 10'd0);
    expect_done(2'b01, 10'd109, 1, 2, "disp3_reload"); rel(3);
    drv_op(2'b11, 4'd0, 10'd0);
    expect_done(2'b01, 10'd109, 1, 0, "exit3b"); rel(2);
    login(4'd2);
    drv_op(2'b00, 4'd0, 10'd0);
    expect_done(2'b01, 10'd237, 1, 2, "disp2_reload"); rel(3);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("pending_expect", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
